// File: rtl/sar_adc_pkg.sv
// Shared types and constants for the SAR ADC controller.
// SAR_CMP_SYNC_EN selects a two-flop comparator synchroniser (SYNC_LAT = 2) instead of one capture flop.
package sar_adc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_e;

`ifdef SAR_CMP_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 1;
`endif

  // Bits needed for a phase counter that runs 0 .. max(settle, timeout)-1.
  function automatic int cnt_width(input int settle, input int timeout);
    int m;
    m = (settle > timeout) ? settle : timeout;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sar_adc_ctrl_if.sv
// Handshake and analog-side signals of the SAR controller.
// master = host/comparator side, slave = the controller itself.
interface sar_adc_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             cmp_p;
  logic             cmp_m;
  logic [WIDTH-1:0] dac_code;
  logic             cmp_en;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             err;

  modport master (
    output start, cmp_p, cmp_m,
    input  dac_code, cmp_en, busy, done, result, err
  );

  modport slave (
    input  start, cmp_p, cmp_m,
    output dac_code, cmp_en, busy, done, result, err
  );
endinterface

// File: rtl/sar_cmp_sync.sv
// Capture chain for the comparator's differential pair (depth SYNC_LAT).
// Built with SAR_CMP_SYNC_EN: two flops per rail; otherwise a single capture flop.
module sar_cmp_sync
  import sar_adc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic cmp_p,
  input  logic cmp_m,
  output logic sp,
  output logic sm,
  output logic resolved
);

  logic [SYNC_LAT-1:0] p_q, p_d;
  logic [SYNC_LAT-1:0] m_q, m_d;

  always_comb begin
`ifdef SAR_CMP_SYNC_EN
    p_d = {p_q[0], cmp_p};
    m_d = {m_q[0], cmp_m};
`else
    p_d = cmp_p;
    m_d = cmp_m;
`endif
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // flop samples the pre-edge value of its neighbours regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q <= '0;
      m_q <= '0;
    end else begin
      p_q <= p_d;
      m_q <= m_d;
    end
  end

  assign sp       = p_q[SYNC_LAT-1];
  assign sm       = m_q[SYNC_LAT-1];
  // Both rails equal (precharge or invalid) is never a decision.
  assign resolved = sp ^ sm;

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: steps a trial code MSB-first through the DAC and
// reads the comparator back. SAR_CMP_SYNC_EN selects the synchroniser depth (see sar_adc_pkg).
module sar_adc_ctrl
  import sar_adc_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int DEC_TIMEOUT   = 8
) (
  input  logic           clk,
  input  logic           rst,
  sar_adc_ctrl_if.slave  bus
);

  localparam int CW = cnt_width(SETTLE_CYCLES, DEC_TIMEOUT);
  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] TOP_CODE = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dac_q, dac_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic sp, sm, resolved;
  logic accept, timeout;

  sar_cmp_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .cmp_p    (bus.cmp_p),
    .cmp_m    (bus.cmp_m),
    .sp       (sp),
    .sm       (sm),
    .resolved (resolved)
  );

  // NOTE: every signal written here gets its default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    dac_d    = dac_q;
    result_d = result_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    done_d   = 1'b0;
    accept   = 1'b0;
    timeout  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SETTLE;
          dac_d   = TOP_CODE;
          idx_d   = IW'(WIDTH-1);
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end

      SETTLE: begin
        if (cnt_q == CW'(SETTLE_CYCLES-1)) begin
          state_d = COMPARE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      COMPARE: begin
        // Early samples still hold pre-strobe data from the capture chain.
        accept  = resolved && (cnt_q >= CW'(SYNC_LAT));
        timeout = !accept && (cnt_q == CW'(DEC_TIMEOUT-1));
        if (accept || timeout) begin
          dac_d[idx_q] = accept & sp & ~sm;
          if (timeout) err_d = 1'b1;
          cnt_d = '0;
          if (idx_q != '0) begin
            dac_d[idx_q - 1'b1] = 1'b1;
            idx_d   = idx_q - 1'b1;
            state_d = SETTLE;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        done_d   = 1'b1;
        result_d = dac_q;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      dac_q    <= '0;
      result_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dac_q    <= dac_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign bus.dac_code = dac_q;
  assign bus.cmp_en   = (state_q == COMPARE);
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Self-checking bench for sar_adc_ctrl: clk-synchronous comparator model plus a
// bit-serial reference of the successive-approximation search.
module tb_sar_adc_ctrl;

  localparam int WIDTH  = 8;
  localparam int SETTLE = 4;
  localparam int TMO    = 8;
`ifdef SAR_CMP_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 1;
`endif
  localparam int P = SETTLE + SYNC + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sar_adc_ctrl_if #(.WIDTH(WIDTH)) bus ();

  sar_adc_ctrl #(
    .WIDTH         (WIDTH),
    .SETTLE_CYCLES (SETTLE),
    .DEC_TIMEOUT   (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Comparator environment
  int vin       = 0;
  int stuck_bit = -1;
  bit hold_p    = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // The bit under trial is the lowest set bit of the trial code.
  function automatic bit is_stuck(input logic [WIDTH-1:0] code);
    int low;
    low = -1;
    for (int k = WIDTH-1; k >= 0; k--) if (code[k]) low = k;
    return (stuck_bit >= 0) && (low == stuck_bit);
  endfunction

  // Latch model: precharged (1,1) unless strobed; resolves to Vin >= DAC while strobed.
  initial begin
    bus.cmp_p = 1'b1;
    bus.cmp_m = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold_p) begin
        bus.cmp_p = 1'b1;
        bus.cmp_m = 1'b0;
      end else if (bus.cmp_en && !is_stuck(bus.dac_code)) begin
        bus.cmp_p = (vin >= int'(bus.dac_code));
        bus.cmp_m = !(vin >= int'(bus.dac_code));
      end else begin
        bus.cmp_p = 1'b1;
        bus.cmp_m = 1'b1;
      end
    end
  end

  // One conversion, entered and left on a falling edge. keep_start leaves start high.
  task automatic run_conv(input int v, input int sbit, input bit hold, input bit keep_start,
                          input string tag);
    int n, b, len, exp_lat;
    logic [WIDTH-1:0] acc, trial;
    bit exp_err, prev_en, got_done, keep;
    vin       = v;
    stuck_bit = sbit;
    hold_p    = hold;
    bus.start = 1'b1;
    acc = '0; trial = '0; b = WIDTH-1; len = 0; n = 0;
    exp_err = 1'b0; prev_en = 1'b0; got_done = 1'b0;
    exp_lat = WIDTH*P + 1 + ((sbit >= 0) ? (TMO - SYNC - 1) : 0);
    while (!got_done && n < 400) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        if (!keep_start) bus.start = 1'b0;
        check({tag, "/busy_after_start"}, 32'(bus.busy), 32'd1);
        check({tag, "/err_cleared"}, 32'(bus.err), 32'd0);
      end
      if (bus.cmp_en) len++;
      if (bus.cmp_en && !prev_en) begin
        trial = acc | (WIDTH'(1) << b);
        check({tag, "/trial_code"}, 32'(bus.dac_code), 32'(trial));
      end
      if (!bus.cmp_en && prev_en) begin
        check({tag, "/compare_len"}, 32'(len), (b == sbit) ? 32'(TMO) : 32'(SYNC + 1));
        keep = hold ? 1'b1 : (v >= int'(trial));
        if (b == sbit) exp_err = 1'b1;
        else if (keep) acc = trial;
        b--;
        len = 0;
      end
      prev_en = bus.cmp_en;
      if (bus.done) got_done = 1'b1;
    end
    check({tag, "/done_seen"}, 32'(got_done), 32'd1);
    if (got_done) begin
      check({tag, "/latency"}, 32'(n - 1), 32'(exp_lat));
      check({tag, "/result"}, 32'(bus.result), 32'(acc));
      check({tag, "/err"}, 32'(bus.err), 32'(exp_err));
      check({tag, "/idle_on_done"}, 32'(bus.busy), 32'd0);
      check({tag, "/dac_holds"}, 32'(bus.dac_code), 32'(acc));
    end
  endtask

  initial begin
    int rises, n, extra;
    bus.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset/dac_code", 32'(bus.dac_code), 32'd0);
    check("reset/result",   32'(bus.result),   32'd0);
    check("reset/cmp_en",   32'(bus.cmp_en),   32'd0);
    check("reset/busy",     32'(bus.busy),     32'd0);
    check("reset/done",     32'(bus.done),     32'd0);
    check("reset/err",      32'(bus.err),      32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_conv(8'hA5, -1, 1'b0, 1'b0, "a5");
    run_conv(8'h00, -1, 1'b0, 1'b0, "zero");
    run_conv(8'hFF, -1, 1'b1, 1'b0, "ff_hold");
    run_conv(8'hFF, 3, 1'b0, 1'b0, "stuck_b3");
    check("stuck_b3/result_f7", 32'(bus.result), 32'hF7);

    // Reset in the middle of the bit-5 COMPARE
    vin = 8'h5A; stuck_bit = -1; hold_p = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("rst_mid/err_cleared", 32'(bus.err), 32'd0);
    rises = 0; n = 0;
    while (rises < 3 && n < 200) begin
      if (bus.cmp_en) begin
        rises++;
        while (bus.cmp_en && rises < 3 && n < 200) begin @(negedge clk); n++; end
      end
      if (rises < 3) begin @(negedge clk); n++; end
    end
    check("rst_mid/bit5_reached", 32'(rises), 32'd3);
    check("rst_mid/bit5_trial", 32'(bus.dac_code & 8'h3F), 32'h20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid/dac_code", 32'(bus.dac_code), 32'd0);
    check("rst_mid/result",   32'(bus.result),   32'd0);
    check("rst_mid/cmp_en",   32'(bus.cmp_en),   32'd0);
    check("rst_mid/busy",     32'(bus.busy),     32'd0);
    check("rst_mid/done",     32'(bus.done),     32'd0);
    check("rst_mid/err",      32'(bus.err),      32'd0);
    @(negedge clk);
    run_conv(8'h3C, -1, 1'b0, 1'b0, "after_rst");

    for (int r = 0; r < 4; r++) run_conv(int'($urandom_range(0, 255)), -1, 1'b0, 1'b0, "random");

    // start held high: conversions chain with exactly one idle cycle (the done cycle)
    for (int r = 0; r < 3; r++) run_conv(int'($urandom_range(0, 255)), -1, 1'b0, 1'b1, "b2b");
    bus.start = 1'b0;
    extra = 0;
    for (int k = 0; k < WIDTH*P + 4; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) extra++;
    end
    check("b2b/no_extra_conversion", 32'(extra), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
